// File: rtl/ifetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_pkg                                                           |
// | Shared constants, request-FSM state type and helpers for ifetch.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package ifetch_pkg;

    localparam logic [1:0]  PCSRC_SEQ        = 2'b00;
    localparam logic [1:0]  PCSRC_BR         = 2'b01;
    localparam logic [1:0]  PCSRC_JAL        = 2'b10;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_BUSY = 2'd1,
        R_DROP = 2'd2
    } req_state_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_pbuf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_pbuf                                                          |
// | One-entry prefetch buffer; flush wins over load, load over pop.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ifetch_pbuf
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    input  logic        load,
    input  logic        flush,
    input  logic        pop,
    input  logic [31:0] din,
    output logic [31:0] pbuf,
    output logic        pbuf_v
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pbuf   <= INST_NOP;
            pbuf_v <= 1'b0;
        end else if (flush) begin
            pbuf_v <= 1'b0;
        end else if (load) begin
            pbuf   <= din;
            pbuf_v <= 1'b1;
        end else if (pop) begin
            pbuf_v <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_unit                                                          |
// | PC holder and instruction fetcher with one-word prefetch/redirect.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        clrn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bjtarget,
    input  logic [31:0] jtarget
);

    req_state_t  req_state;
    req_state_t  nxt_state;
    logic        consume;
    logic        redirect;
    logic        ack_busy;
    logic [31:0] target;
    logic        nxt_valid;
    logic [31:0] nxt_inst;
    logic [31:0] nxt_pc;
    logic        pb_load;
    logic        pb_flush;
    logic        pb_pop;
    logic        nxt_pbuf_v;
    logic        can_issue;
    logic        issue;
    logic [31:0] issue_addr;
    logic [31:0] pbuf;
    logic        pbuf_v;

    ifetch_pbuf u_pbuf (
        .clk    (clk),
        .clrn   (clrn),
        .load   (pb_load),
        .flush  (pb_flush),
        .pop    (pb_pop),
        .din    (imem_rdata),
        .pbuf   (pbuf),
        .pbuf_v (pbuf_v)
    );

    // While inst_valid is low, pc doubles as the address of the next fetch.
    always_comb begin
        consume    = inst_valid & inst_ready;
        redirect   = consume & ((pcsrc == PCSRC_BR) | (pcsrc == PCSRC_JAL));
        target     = align_word((pcsrc == PCSRC_BR) ? bjtarget : jtarget);
        ack_busy   = (req_state == R_BUSY) & imem_ack;
        nxt_valid  = inst_valid;
        nxt_inst   = inst;
        nxt_pc     = pc;
        pb_load    = 1'b0;
        pb_flush   = 1'b0;
        pb_pop     = 1'b0;
        if (redirect) begin
            nxt_valid = 1'b0;
            nxt_pc    = target;
            pb_flush  = 1'b1;
        end else if (consume) begin
            nxt_pc = pc + 32'd4;
            if (pbuf_v) begin
                nxt_inst = pbuf;
                pb_pop   = 1'b1;
            end else if (ack_busy) begin
                nxt_inst = imem_rdata;
            end else begin
                nxt_valid = 1'b0;
            end
        end else if (ack_busy) begin
            if (!inst_valid) begin
                nxt_inst  = imem_rdata;
                nxt_valid = 1'b1;
            end else begin
                pb_load = 1'b1;
            end
        end
        nxt_pbuf_v = pb_flush ? 1'b0 : (pb_load ? 1'b1 : (pb_pop ? 1'b0 : pbuf_v));

        // A redirect that coincides with an ack retires to idle first.
        can_issue  = (req_state == R_IDLE) | (ack_busy & ~redirect);
        issue      = can_issue & (~nxt_valid | ~nxt_pbuf_v);
        issue_addr = nxt_valid ? (nxt_pc + 32'd4) : nxt_pc;

        nxt_state = req_state;
        case (req_state)
            R_IDLE: if (issue) nxt_state = R_BUSY;
            R_BUSY: begin
                if (imem_ack)      nxt_state = issue ? R_BUSY : R_IDLE;
                else if (redirect) nxt_state = R_DROP;
            end
            R_DROP: if (imem_ack) nxt_state = R_IDLE;
            default: nxt_state = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            req_state  <= R_IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= INST_NOP;
            pc         <= RESET_PC;
        end else begin
            req_state  <= nxt_state;
            imem_req   <= (nxt_state != R_IDLE);
            if (issue) imem_addr <= issue_addr;
            inst_valid <= nxt_valid;
            inst       <= nxt_inst;
            pc         <= nxt_pc;
        end
    end

    assign pc4    = pc + 32'd4;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifetch_unit                                                       |
// | Directed self-checking bench for ifetch_unit with a simple memory.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ifetch_unit;
    import ifetch_pkg::*;

    logic        clk;
    logic        clrn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  pcsrc;
    logic [31:0] bjtarget;
    logic [31:0] jtarget;

    int          errors = 0;
    int          checks = 0;
    int          mem_delay;
    int          mem_cnt;
    logic [31:0] mem_xor;
    int          n_acks = 0;
    int          acks_snap;

    ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst       (inst),
        .pc         (pc),
        .pc4        (pc4),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .rs1        (rs1),
        .rs2        (rs2),
        .rd         (rd),
        .pcsrc      (pcsrc),
        .bjtarget   (bjtarget),
        .jtarget    (jtarget)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: acks after the request has been held mem_delay cycles; data = addr ^ mem_xor.
    always @(posedge clk or negedge clrn) begin
        if (!clrn)                      mem_cnt <= 0;
        else if (!imem_req || imem_ack) mem_cnt <= 0;
        else                            mem_cnt <= mem_cnt + 1;
    end
    assign imem_ack   = imem_req && (mem_cnt >= mem_delay);
    assign imem_rdata = imem_addr ^ mem_xor;

    always @(posedge clk) if (imem_req && imem_ack) n_acks <= n_acks + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        clrn = 1'b0; inst_ready = 1'b0; pcsrc = PCSRC_SEQ;
        bjtarget = 32'h0; jtarget = 32'h0; mem_delay = 0; mem_xor = 32'h0;
        tick(); tick();
        chk("rst_req",   {31'h0, imem_req}, 32'h0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst",  inst, 32'h0000_0013);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_pbufv", {31'h0, dut.u_pbuf.pbuf_v}, 32'h0);
        chk("rst_state", 32'(dut.req_state), 32'(R_IDLE));

        // Stream: first request right after release, one instruction per cycle after.
        clrn = 1'b1; inst_ready = 1'b1;
        tick();
        chk("e1_req",   {31'h0, imem_req}, 32'h1);
        chk("e1_addr",  imem_addr, 32'h0);
        chk("e1_valid", {31'h0, inst_valid}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stream_valid", {31'h0, inst_valid}, 32'h1);
            chk("stream_pc",    pc, 32'(4 * k));
            chk("stream_inst",  inst, 32'(4 * k));
        end
        chk("stream_opcode", {25'h0, opcode}, 32'h08);
        chk("stream_addr",   imem_addr, 32'hC);

        // Backpressure at pc=0x8: one prefetch completes, then the bus idles.
        inst_ready = 1'b0;
        acks_snap  = n_acks;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_pc",    pc, 32'h8);
            chk("bp_inst",  inst, 32'h8);
            chk("bp_req",   {31'h0, imem_req}, 32'h0);
            chk("bp_pbufv", {31'h0, dut.u_pbuf.pbuf_v}, 32'h1);
        end
        chk("bp_acks", 32'(n_acks - acks_snap), 32'h1);
        inst_ready = 1'b1;
        tick();
        chk("bp_rel_pc1",   pc, 32'hC);
        chk("bp_rel_inst1", inst, 32'hC);
        chk("bp_rel_addr",  imem_addr, 32'h10);
        tick();
        chk("bp_rel_pc2",   pc, 32'h10);
        chk("bp_rel_val2",  {31'h0, inst_valid}, 32'h1);

        // Drop: jal to 0x100 while the 0x14 fetch is still waiting.
        mem_delay = 3; pcsrc = PCSRC_JAL; jtarget = 32'h100;
        tick();
        pcsrc = PCSRC_SEQ;
        for (int k = 0; k < 3; k++) begin
            chk("drop_state", 32'(dut.req_state), 32'(R_DROP));
            chk("drop_addr",  imem_addr, 32'h14);
            chk("drop_req",   {31'h0, imem_req}, 32'h1);
            chk("drop_valid", {31'h0, inst_valid}, 32'h0);
            tick();
        end
        chk("drop_done_state", 32'(dut.req_state), 32'(R_IDLE));
        chk("drop_done_valid", {31'h0, inst_valid}, 32'h0);
        mem_delay = 0;
        tick();
        chk("drop_new_addr", imem_addr, 32'h100);
        chk("drop_new_req",  {31'h0, imem_req}, 32'h1);
        tick();
        chk("drop_tgt_pc",    pc, 32'h100);
        chk("drop_tgt_valid", {31'h0, inst_valid}, 32'h1);

        // Misaligned branch target is word-aligned; ack arrives in the redirect cycle.
        pcsrc = PCSRC_BR; bjtarget = 32'h203;
        tick();
        pcsrc = PCSRC_SEQ;
        chk("al_state", 32'(dut.req_state), 32'(R_IDLE));
        chk("al_pc",    pc, 32'h200);
        chk("al_valid", {31'h0, inst_valid}, 32'h0);
        tick();
        chk("al_addr", imem_addr, 32'h200);
        tick();
        chk("al_tgt_pc",   pc, 32'h200);
        chk("al_tgt_inst", inst, 32'h200);

        // Same-cycle ack and redirect to 0x40.
        pcsrc = PCSRC_BR; bjtarget = 32'h40;
        tick();
        pcsrc = PCSRC_SEQ;
        chk("sc_state", 32'(dut.req_state), 32'(R_IDLE));
        chk("sc_req",   {31'h0, imem_req}, 32'h0);
        chk("sc_valid", {31'h0, inst_valid}, 32'h0);
        tick();
        chk("sc_addr", imem_addr, 32'h40);
        chk("sc_req2", {31'h0, imem_req}, 32'h1);
        tick();
        chk("sc_tgt_pc", pc, 32'h40);

        // pcsrc=11 behaves as sequential.
        pcsrc = 2'b11; bjtarget = 32'h999; jtarget = 32'h777;
        tick();
        pcsrc = PCSRC_SEQ;
        chk("p11_pc",    pc, 32'h44);
        chk("p11_valid", {31'h0, inst_valid}, 32'h1);

        // Decode slices: word at 0x48 becomes 0xFE12DAB3.
        mem_xor = 32'hFE12_DAFB;
        tick();
        mem_xor = 32'h0;
        chk("fld_inst",   inst, 32'hFE12_DAB3);
        chk("fld_pc4",    pc4, 32'h4C);
        chk("fld_opcode", {25'h0, opcode}, 32'h33);
        chk("fld_funct3", {29'h0, funct3}, 32'h5);
        chk("fld_funct7", {25'h0, funct7}, 32'h7F);
        chk("fld_rs1",    {27'h0, rs1}, 32'h5);
        chk("fld_rs2",    {27'h0, rs2}, 32'h1);
        chk("fld_rd",     {27'h0, rd}, 32'h15);

        // Asynchronous reset while a request is outstanding.
        mem_delay = 5; inst_ready = 1'b0;
        tick();
        chk("ar_state", 32'(dut.req_state), 32'(R_BUSY));
        chk("ar_req",   {31'h0, imem_req}, 32'h1);
        #2;
        clrn = 1'b0;
        #1;
        chk("ar_req_low",   {31'h0, imem_req}, 32'h0);
        chk("ar_valid_low", {31'h0, inst_valid}, 32'h0);
        chk("ar_pc",        pc, 32'h0);
        chk("ar_addr",      imem_addr, 32'h0);
        chk("ar_inst",      inst, 32'h0000_0013);
        tick(); tick();
        chk("ar_hold_req", {31'h0, imem_req}, 32'h0);
        mem_delay = 0; inst_ready = 1'b1; clrn = 1'b1;
        tick();
        chk("ar_restart_req",  {31'h0, imem_req}, 32'h1);
        chk("ar_restart_addr", imem_addr, 32'h0);
        tick();
        chk("ar_restart_pc",    pc, 32'h0);
        chk("ar_restart_valid", {31'h0, inst_valid}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage directly upstream of the decode/control unit. Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake, with one-word prefetch. Presents the current instruction and its pre-sliced decode fields (opcode, funct3, funct7, register indices) to decode. Consumes the decoder's `pcsrc` plus datapath-computed targets to redirect, discarding stale prefetches.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, address of the first fetch after reset.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `clrn`  in  1  reset; asynchronous, active-low.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ack`  in  1  one-cycle pulse; `imem_rdata` valid.
- `imem_rdata`  in  32  fetched word.
- `inst_valid`  out  1  `inst`/`pc` hold a valid instruction.
- `inst_ready`  in  1  decode accepts the instruction this cycle.
- `inst`  out  32  held instruction word.
- `pc`, `pc4`  out  32 each  address of `inst`, and `pc`+4.
- `opcode` / `funct3` / `funct7`  out  7/3/7  `inst[6:0]`, `inst[14:12]`, `inst[31:25]`.
- `rs1` / `rs2` / `rd`  out  5 each  `inst[19:15]`, `inst[24:20]`, `inst[11:7]`.
- `pcsrc`  in  2  next-PC select for the consumed instruction: 00 seq, 01 branch/jalr, 10 jal, 11 treated as 00.
- `bjtarget`  in  32  target for `pcsrc`=01.
- `jtarget`  in  32  target for `pcsrc`=10.

## Operation
- Consume C = `inst_valid & inst_ready`. Redirect R = C & `pcsrc` ∈ {01,10}. Targets have bits [1:0] forced to 0.
- Request FSM: R_IDLE, R_BUSY (one request outstanding), R_DROP (outstanding, response to be discarded). At most one outstanding request. `imem_req` and `imem_addr` stay stable from assertion until the ack is sampled.
- Fetch address when issuing:
  - `pc` (fetch target) when `!inst_valid`.
  - `pc`+4 when `inst_valid & !pbuf_v`.
  - No issue when `inst_valid & pbuf_v`.
- On an ack in R_BUSY:
  - If `!inst_valid`: word goes to `inst`.
  - Else if C without R: word bypasses into `inst` and `pc` advances by 4.
  - Else: word goes to the one-entry prefetch buffer (`pbuf`, `pbuf_v`=1).
- On C without R: if `pbuf_v`, `inst`←`pbuf` and `pbuf_v`←0. Otherwise, with no bypass ack, `inst_valid`←0 and the fetch target becomes `pc`+4.
- On R:
  - `inst_valid`←0, `pbuf_v`←0, fetch target←target.
  - If a request is outstanding and not acked this cycle: go to R_DROP.
  - If acked this cycle: discard the word and go to R_IDLE.
- R_DROP: keep the request asserted with the old address. On ack, discard the data and go to R_IDLE.
- A second R while in R_DROP only updates the fetch target.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `inst_valid`=0, `inst`=32'h0000_0013 (NOP), `pc`=`RESET_PC`, `pbuf_v`=0, FSM=R_IDLE.
- First edge after `clrn` rises: `imem_req`=1, `imem_addr`=`RESET_PC`.
- Ack sampled at edge N → `inst_valid`=1 after edge N. The next request is issued at edge N, so `imem_req` may stay high continuously.
- Memory with 1-cycle ack and `inst_ready`=1: first `inst_valid` 2 cycles after reset release, then one instruction per cycle.
- Redirect penalty with 1-cycle memory and no drop: target instruction valid 2 cycles after the R edge.
- Decode fields are pure slices of the registered `inst`; no combinational path from `pcsrc` or targets to any output.
- `clrn` low at any time: all state returns to reset values immediately. A pending ack is not tracked across reset.

## Structure
- Shared package `ifetch_pkg`:
  - `PCSRC_SEQ`=2'b00, `PCSRC_BR`=2'b01, `PCSRC_JAL`=2'b10.
  - `INST_NOP`=32'h0000_0013.
  - Request-FSM state enum.
  - Default `RESET_PC`.
- Sub-module `ifetch_pbuf`: one-entry prefetch buffer with load/flush/pop, holding `pbuf` and `pbuf_v`.

## Test plan
- Reset/stream: `clrn` low, then high. Memory acks 1 cycle after req with rdata=addr, `inst_ready`=1 → all reset values hold during reset; `pc`=0,4,8,… one per cycle from cycle 2; `opcode`=`inst[6:0]`.
- Backpressure: `inst_ready`=0 for 5 cycles at `pc`=0x8 → `inst`/`pc` stable; exactly one req (0xC) completes into `pbuf`, then `imem_req`=0. On release, 0x8, 0xC, 0x10 appear back-to-back with no gap or duplicate.
- Drop: at `pc`=0x4, consume with `pcsrc`=10, `jtarget`=0x100, while the 0x8 request is unacked (memory delays 3 cycles) → FSM R_DROP, `imem_addr` stays 0x8 until ack, word 0x8 never valid, next valid `pc`=0x100.
- Alignment: `pcsrc`=01, `bjtarget`=0x203 → next `imem_addr`=0x200, `pc`=0x200.
- Same-cycle ack and redirect: ack for `pc`+4 arrives in the R cycle with `bjtarget`=0x40 → word discarded, no R_DROP, req to 0x40 at the next edge.
- Async reset mid-request: `clrn` low while R_BUSY → `imem_req`=0 and `inst_valid`=0 immediately, without a clock. After release, the fetch restarts at `RESET_PC`.
